mem_responder: RTL



---
 rtl/mem_responder.sv | 104 ++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency word-addressed RAM behind the MAR/MDR datapath.
// A Read/Write strobe is latched in IDLE. The access completes WAIT_CYCLES+1
// edges later, and Done then pulses for one cycle. A strobe that stays high
// parks the FSM in HOLD, so each request level produces exactly one access.
// Optional build macro MEM_ERR_EN adds the Err port (out-of-range flag in DONE).
module mem_responder #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 9,
   parameter int DEPTH       = 512,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              Clock,
   input  logic              Clear,
   input  logic              Read,
   input  logic              Write,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] Mdata_in,
   output logic [DATA_W-1:0] Mdata_out,
   output logic              Done,
   output logic              Busy
`ifdef MEM_ERR_EN
   ,
   output logic              Err
`endif
);

   localparam int CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE, HOLD} state_t;

   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } req_t;

   state_t            state, state_nx;
   req_t              req;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              req_any, in_range, op_now;
   logic [MEM_AW-1:0] idx;

   assign req_any  = Read | Write;
   // The extra leading zero keeps the compare meaningful when DEPTH == 2**ADDR_W.
   assign in_range = ({1'b0, req.addr} < DEPTH_V);
   assign idx      = req.addr[MEM_AW-1:0];
   assign op_now   = (state == ACCESS) && (cnt == '0);

`ifdef MEM_ERR_EN
   assign Err = Done & ~in_range;
`endif

   // Next-state decode; Busy and Done come straight from the state.
   always_comb begin
      state_nx = state;
      Busy     = 1'b0;
      Done     = 1'b0;
      case (state)
         IDLE:    if (req_any) state_nx = ACCESS;
         ACCESS: begin
            Busy = 1'b1;
            if (cnt == '0) state_nx = DONE;
         end
         DONE: begin
            Done     = 1'b1;
            state_nx = req_any ? HOLD : IDLE;
         end
         HOLD:    if (!req_any) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State, request latch, wait counter and read-data register.
   always_ff @(posedge Clock) begin
      if (Clear) begin
         state     <= IDLE;
         cnt       <= '0;
         Mdata_out <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: if (req_any) begin
               // Write wins when both strobes are high.
               req <= '{wr: Write, addr: address, data: Mdata_in};
               cnt <= CNT_W'(WAIT_CYCLES);
            end
            ACCESS: begin
               if (cnt != '0)  cnt       <= cnt - CNT_W'(1);
               else if (!req.wr) Mdata_out <= in_range ? mem[idx] : '0;
            end
            default: ;
         endcase
      end
   end

   // Write port. The array has no reset, and Clear on the op edge drops the write.
   always_ff @(posedge Clock) begin
      if (!Clear && op_now && req.wr && in_range) mem[idx] <= req.data;
   end

endmodule
